mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Load/store unit for the EX/MEM stage. It takes one live memory
// instruction, turns it into a single word-aligned bus transaction with
// byte-lane strobes, and stalls the pipeline until the memory answers.
// Reserved encodings and misaligned accesses never reach the bus. They
// are reported with a one-cycle error pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; decode EX/MEM slot, accept or reject
// ST_REQ  | bus_req asserted with latched request; waiting for bus_ack
// ST_DONE | access retired; mem_done pulse, dead cycle before next accept
module mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic [1:0]        ex_size,
  input  logic              ex_uns,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              stall,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_err
);

  // The wait counter only has to reach TIMEOUT-1; the abort is taken on
  // the REQ cycle that would have pushed it to TIMEOUT.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         wdata_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          lane_q;
  logic [31:0]         rdata_q;

  logic                is_access;
  logic                misalign;
  logic                accept;
  logic                reject;
  logic                capture;
  logic                req_c;
  logic                stall_c;
  logic                done_c;
  logic [3:0]          wstrb_c;
  logic [31:0]         wdata_c;
  logic [31:0]         lane_data;
  logic [31:0]         load_ext;

  // Decode the EX/MEM slot: legal single-direction access vs. anything
  // that must be refused without touching the bus.
  always_comb begin
    is_access = ex_rd ^ ex_wr;
    misalign  = 1'b0;
    case (ex_size)
      SZ_HALF: misalign = ex_addr[0];
      SZ_WORD: misalign = (ex_addr[1:0] != 2'b00);
      SZ_RSVD: misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
    accept = (state_q == ST_IDLE) && ex_valid && is_access && !misalign;
    reject = (state_q == ST_IDLE) && ex_valid &&
             ((ex_rd && ex_wr) || (is_access && misalign));
  end

  // Store lane steering: strobes follow the byte offset and the data is
  // replicated so the selected lanes carry the right bytes.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    if (ex_wr) begin
      case (ex_size)
        SZ_BYTE: begin
          wstrb_c = 4'b0001 << ex_addr[1:0];
          wdata_c = {4{ex_wdata[7:0]}};
        end
        SZ_HALF: begin
          wstrb_c = 4'b0011 << ex_addr[1:0];
          wdata_c = {2{ex_wdata[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = ex_wdata;
        end
      endcase
    end
  end

  // Access sequencing: next state, wait counter, error pulse and the
  // handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    req_c   = 1'b0;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          stall_c = 1'b1;
        end else if (reject) begin
          err_d = 1'b1;
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (bus_ack) begin
          state_d = ST_DONE;
          capture = !we_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load result: pick the addressed lane and sign/zero extend it.
  always_comb begin
    lane_data = bus_rdata >> {lane_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
      SZ_HALF: load_ext = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = lane_data;
    endcase
  end

  // State, counter and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request latch: held stable for the whole REQ phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
    end else if (accept) begin
      we_q    <= ex_wr;
      addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
      wstrb_q <= wstrb_c;
      wdata_q <= wdata_c;
      size_q  <= ex_size;
      uns_q   <= ex_uns;
      lane_q  <= ex_addr[1:0];
    end
  end

  // Load data register: only updated by an acknowledged load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (capture) begin
      rdata_q <= load_ext;
    end
  end

  assign bus_req   = req_c;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign stall     = stall_c;
  assign mem_done  = done_c;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT=4). A small pipeline model holds
// the EX/MEM slot while stall is high and retires it otherwise.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_rd, ex_wr, ex_uns;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        stall, mem_done, mem_err;
  logic [31:0] mem_rdata;

  int n_vec, n_err;
  int nreq, nstall, ndone, nerr, done_at;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;

  mem_access #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_size(ex_size),
    .ex_uns(ex_uns), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction and run 10 cycles; ack on the ack_at-th REQ cycle (0 = never).
  task automatic do_access(input logic v, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdat);
    logic moved;
    nreq = 0; nstall = 0; ndone = 0; nerr = 0; done_at = -1;
    cap_we = 1'bx; cap_addr = 'x; cap_wdata = 'x; cap_strb = 'x;
    @(posedge clk); #1;
    ex_valid = v; ex_rd = rd; ex_wr = wr; ex_size = sz; ex_uns = uns;
    ex_addr = addr; ex_wdata = wd; bus_rdata = rdat;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_req) begin
        nreq++;
        cap_we = bus_we; cap_addr = bus_addr; cap_strb = bus_wstrb; cap_wdata = bus_wdata;
      end
      if (stall) nstall++;
      if (mem_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (mem_err) nerr++;
      bus_ack = bus_req && (nreq == ack_at);
      // pipeline flushes the slot once it moves on or the access times out
      moved = !stall || (bus_req && nreq == 4 && !bus_ack);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (moved) ex_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_size = 0; ex_uns = 0;
    ex_addr = 0; ex_wdata = 0; bus_ack = 0; bus_rdata = 0;
    #1;
    check("rst_bus_req",   {31'b0, bus_req},  32'h0);
    check("rst_stall",     {31'b0, stall},    32'h0);
    check("rst_mem_rdata", mem_rdata,         32'h0);
    check("rst_bus_addr",  bus_addr,          32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // LB 0x1003, ack on second REQ cycle
    do_access(1, 1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 2, 32'h80FF_0000);
    check("lb_addr",   cap_addr,  32'h0000_1000);
    check("lb_strb",   {28'b0, cap_strb}, 32'h0);
    check("lb_we",     {31'b0, cap_we},   32'h0);
    check("lb_rdata",  mem_rdata, 32'hFFFF_FF80);
    check("lb_done",   ndone,     1);
    check("lb_stall",  nstall,    3);
    check("lb_req",    nreq,      2);

    // SH 0x2002, ack on first REQ cycle
    do_access(1, 0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h0);
    check("sh_strb",   {28'b0, cap_strb}, 32'h0000_000C);
    check("sh_wdata",  cap_wdata, 32'hBEEF_BEEF);
    check("sh_addr",   cap_addr,  32'h0000_2000);
    check("sh_we",     {31'b0, cap_we},   32'h1);
    check("sh_done",   ndone,     1);
    check("sh_lat",    done_at,   2);
    check("sh_keep",   mem_rdata, 32'hFFFF_FF80);

    // LW misaligned
    do_access(1, 1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 1, 32'h0);
    check("lwmis_req",   nreq,   0);
    check("lwmis_err",   nerr,   1);
    check("lwmis_stall", nstall, 0);
    check("lwmis_done",  ndone,  0);

    // LHU 0x0002
    do_access(1, 1, 0, 2'b01, 1, 32'h0000_0002, 32'h0, 1, 32'h8001_1234);
    check("lhu_rdata", mem_rdata, 32'h0000_8001);
    check("lhu_addr",  cap_addr,  32'h0000_0000);

    // SB 0x0005
    do_access(1, 0, 1, 2'b00, 0, 32'h0000_0005, 32'h1234_56A5, 1, 32'h0);
    check("sb_strb",  {28'b0, cap_strb}, 32'h0000_0002);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("sb_addr",  cap_addr,  32'h0000_0004);

    // LH signed lane 0
    do_access(1, 1, 0, 2'b01, 0, 32'h0000_0000, 32'h0, 3, 32'h1234_8765);
    check("lh_rdata", mem_rdata, 32'hFFFF_8765);
    check("lh_stall", nstall, 4);

    // LW aligned
    do_access(1, 1, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    check("lw_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("lw_strb",  {28'b0, cap_strb}, 32'h0);

    // rd and wr both set
    do_access(1, 1, 1, 2'b10, 0, 32'h0000_0020, 32'h0, 1, 32'h0);
    check("rw_req", nreq, 0);
    check("rw_err", nerr, 1);

    // reserved size
    do_access(1, 1, 0, 2'b11, 0, 32'h0000_0020, 32'h0, 1, 32'h0);
    check("rsv_req", nreq, 0);
    check("rsv_err", nerr, 1);
    check("rsv_stall", nstall, 0);

    // store with no ack: timeout
    do_access(1, 0, 1, 2'b10, 0, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0);
    check("to_req",   nreq,  4);
    check("to_err",   nerr,  1);
    check("to_done",  ndone, 0);
    check("to_stall", nstall, 5);
    check("to_keep",  mem_rdata, 32'hDEAD_BEEF);
    check("to_idle",  {31'b0, bus_req}, 32'h0);

    // idle slot and non-memory instruction
    do_access(0, 1, 0, 2'b10, 0, 32'h0000_0050, 32'h0, 1, 32'h0);
    check("inv_req",  nreq + nstall + nerr + ndone, 0);
    do_access(1, 0, 0, 2'b10, 0, 32'h0000_0050, 32'h0, 1, 32'h0);
    check("nop_req",  nreq + nstall + nerr + ndone, 0);

    // reset during REQ, late ack ignored
    @(posedge clk); #1;
    ex_valid = 1; ex_rd = 0; ex_wr = 1; ex_size = 2'b10; ex_addr = 32'h40; ex_wdata = 32'h1122_3344;
    @(negedge clk);
    check("rr_accept", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_in_req", {31'b0, bus_req}, 32'h1);
    #2 rst_n = 1'b0; ex_valid = 1'b0;
    #1;
    check("rr_req",   {31'b0, bus_req},  32'h0);
    check("rr_we",    {31'b0, bus_we},   32'h0);
    check("rr_strb",  {28'b0, bus_wstrb}, 32'h0);
    check("rr_addr",  bus_addr,  32'h0);
    check("rr_wdata", bus_wdata, 32'h0);
    check("rr_rdata", mem_rdata, 32'h0);
    check("rr_stall", {31'b0, stall}, 32'h0);
    check("rr_pulse", {30'b0, mem_done, mem_err}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(posedge clk); #1 bus_ack = 1'b0;
    ndone = 0; nerr = 0; nreq = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_done) ndone++;
      if (mem_err) nerr++;
      if (bus_req) nreq++;
    end
    check("rr_after", ndone + nerr + nreq, 0);
    check("rr_rdata2", mem_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
